// File: rtl/seg7_frame_reader_if.sv
// Segment-stream receive interface: pattern strobes in, decoded frame out.
// master = pattern source / frame consumer, slave = the frame reader.
interface seg7_frame_reader_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_W      = 14
);
    logic                      seg_valid;
    logic                      frame_start;
    logic [6:0]                seg_in;
    logic [4*NUM_DIGITS-1:0]   digits_out;
    logic [BIN_W-1:0]          bin_out;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic                      frame_valid;
    logic                      pat_err;
    logic                      timeout;

    modport master (
        output seg_valid, frame_start, seg_in,
        input  digits_out, bin_out, blank_mask, frame_valid, pat_err, timeout
    );

    modport slave (
        input  seg_valid, frame_start, seg_in,
        output digits_out, bin_out, blank_mask, frame_valid, pat_err, timeout
    );
endinterface

// File: rtl/seg7_frame_reader.sv
// Recovers digits from a stream of active-low 7-segment patterns (abcdefg, bit6 = a),
// assembles NUM_DIGITS of them (MSD first) into a frame and presents packed nibbles,
// the binary value and blank/error status. Only complete frames reach the outputs.
module seg7_frame_reader #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_W      = 14,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_frame_reader_if.slave bus
);
    localparam int unsigned DigW = 4 * NUM_DIGITS;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [15:0]         gap_q, gap_d;
    logic [DigW-1:0]     work_digits_q, work_digits_d;
    logic [BIN_W-1:0]    acc_q, acc_d;
    logic [NUM_DIGITS-1:0] work_blank_q, work_blank_d;
    logic                work_err_q, work_err_d;

    logic [DigW-1:0]     digits_q, digits_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [NUM_DIGITS-1:0] blank_mask_q, blank_mask_d;
    logic                pat_err_q, pat_err_d;
    logic                frame_valid_q, frame_valid_d;
    logic                timeout_q, timeout_d;

    logic [3:0]          dec_nib;
    logic [3:0]          dec_val;
    logic                dec_blank;
    logic                dec_err;
    logic                begin_frame;
    logic [15:0]         gap_inc;

    // Pattern decode: legal digits map to 0-9, blank to F, anything else to E.
    always_comb begin
        dec_nib   = 4'hE;
        dec_blank = 1'b0;
        dec_err   = 1'b1;
        case (bus.seg_in)
            7'b0000001: begin dec_nib = 4'd0; dec_err = 1'b0; end
            7'b1001111: begin dec_nib = 4'd1; dec_err = 1'b0; end
            7'b0010010: begin dec_nib = 4'd2; dec_err = 1'b0; end
            7'b0000110: begin dec_nib = 4'd3; dec_err = 1'b0; end
            7'b1001100: begin dec_nib = 4'd4; dec_err = 1'b0; end
            7'b0100100: begin dec_nib = 4'd5; dec_err = 1'b0; end
            7'b0100000: begin dec_nib = 4'd6; dec_err = 1'b0; end
            7'b0001111: begin dec_nib = 4'd7; dec_err = 1'b0; end
            7'b0000000: begin dec_nib = 4'd8; dec_err = 1'b0; end
            7'b0000100: begin dec_nib = 4'd9; dec_err = 1'b0; end
            7'b1111111: begin dec_nib = 4'hF; dec_blank = 1'b1; dec_err = 1'b0; end
            default:    ;
        endcase
        // Blank and illegal digits add nothing to the binary value.
        dec_val = (dec_blank || dec_err) ? 4'd0 : dec_nib;
    end

    assign gap_inc = gap_q + 16'd1;

    // Next-state: frame assembly FSM, working registers and output registers.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        work_digits_d = work_digits_q;
        acc_d         = acc_q;
        work_blank_d  = work_blank_q;
        work_err_d    = work_err_q;
        digits_d      = digits_q;
        bin_d         = bin_q;
        blank_mask_d  = blank_mask_q;
        pat_err_d     = pat_err_q;
        frame_valid_d = 1'b0;
        timeout_d     = timeout_q;
        begin_frame   = 1'b0;

        unique case (state_q)
            StIdle: begin
                begin_frame = bus.seg_valid && bus.frame_start;
            end
            StCollect: begin
                if (bus.seg_valid && bus.frame_start) begin
                    // Restart silently; the partial frame is simply dropped.
                    begin_frame = 1'b1;
                end else if (bus.seg_valid) begin
                    work_digits_d = (work_digits_q << 4) | DigW'(dec_nib);
                    acc_d         = (acc_q << 3) + (acc_q << 1) + BIN_W'(dec_val);
                    work_blank_d  = (work_blank_q << 1) | NUM_DIGITS'(dec_blank);
                    work_err_d    = work_err_q | dec_err;
                    gap_d         = '0;
                    if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
                        state_d = StDone;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end else if (gap_inc == 16'(TIMEOUT)) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                    gap_d     = '0;
                    idx_d     = '0;
                end else begin
                    gap_d = gap_inc;
                end
            end
            StDone: begin
                digits_d      = work_digits_q;
                bin_d         = acc_q;
                blank_mask_d  = work_blank_q;
                pat_err_d     = work_err_q;
                frame_valid_d = 1'b1;
                timeout_d     = 1'b0;
                state_d       = StIdle;
                // A frame_start strobe here is taken immediately so nothing is lost.
                begin_frame   = bus.seg_valid && bus.frame_start;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (begin_frame) begin
            work_digits_d = DigW'(dec_nib);
            acc_d         = BIN_W'(dec_val);
            work_blank_d  = NUM_DIGITS'(dec_blank);
            work_err_d    = dec_err;
            idx_d         = IdxW'(1);
            gap_d         = '0;
            state_d       = (NUM_DIGITS == 1) ? StDone : StCollect;
        end
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            gap_q         <= '0;
            work_digits_q <= '0;
            acc_q         <= '0;
            work_blank_q  <= '0;
            work_err_q    <= 1'b0;
            digits_q      <= '0;
            bin_q         <= '0;
            blank_mask_q  <= '0;
            pat_err_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            work_digits_q <= work_digits_d;
            acc_q         <= acc_d;
            work_blank_q  <= work_blank_d;
            work_err_q    <= work_err_d;
            digits_q      <= digits_d;
            bin_q         <= bin_d;
            blank_mask_q  <= blank_mask_d;
            pat_err_q     <= pat_err_d;
            frame_valid_q <= frame_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.digits_out  = digits_q;
    assign bus.bin_out     = bin_q;
    assign bus.blank_mask  = blank_mask_q;
    assign bus.pat_err     = pat_err_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.timeout     = timeout_q;
endmodule
